// File: rtl/memory_master_pkg.sv
// Shared types and constants for the memory burst master.
//   state_t     : burst FSM states
//   op_t        : command opcode (cmd_write value)
//   WORD_STRIDE : byte distance between consecutive words
//   word_align  : clears the byte-offset bits of an address
package memory_master_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned WORD_STRIDE = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_HOLD,
    WR_DATA,
    WR_REQ,
    WR_WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/memory_burst_master_if.sv
// Bus bundle of the memory burst master: command, write-data, read-data,
// status and memory-port signals.
//   modport master : the burst master itself
//   modport slave  : controller, data producer/consumer and memory side
interface memory_burst_master_if
  import memory_master_pkg::*;
#(
  parameter int unsigned LENGTH_WIDTH = 8
) ();

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_W-1:0]       cmd_address;
  logic [LENGTH_WIDTH-1:0] cmd_length;

  logic [DATA_W-1:0]       wr_data;
  logic                    wr_valid;
  logic                    wr_ready;

  logic [DATA_W-1:0]       rd_data;
  logic                    rd_valid;
  logic                    rd_ready;

  logic                    done;
  logic                    error;

  logic                    memory_read;
  logic                    memory_write;
  logic [ADDR_W-1:0]       address;
  logic [DATA_W-1:0]       write_data;
  logic [DATA_W-1:0]       read_sync;
  logic                    sync_read_response;
  logic                    sync_write_response;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_length,
    input  wr_data, wr_valid, rd_ready,
    input  read_sync, sync_read_response, sync_write_response,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, error,
    output memory_read, memory_write, address, write_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_length,
    output wr_data, wr_valid, rd_ready,
    output read_sync, sync_read_response, sync_write_response,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, error,
    input  memory_read, memory_write, address, write_data
  );

endinterface

// File: rtl/memory_master_timeout.sv
// Restartable down-counter that flags a memory response wait as expired.
//   clk, reset : clock, async active-low reset
//   start      : reload (asserted in the request cycle before the wait)
//   active     : wait in progress, count down
//   expire_c   : high in the last wait cycle if no response has ended it
module memory_master_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count_q;

  // Loads N-1 so the N-th wait cycle sees zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (active && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign expire_c = active && (count_q == '0);

endmodule

// File: rtl/memory_burst_master.sv
// Burst initiator for the word-addressed synchronous memory port.
// Takes read/write burst commands (cmd_length+1 words), issues one
// memory_read/memory_write strobe per word and streams data over the
// wr_*/rd_* valid/ready channels. done pulses on completion.
//   clk, reset : clock, async active-low reset
//   bus        : memory_burst_master_if.master (command, data, status, memory)
// Build option: MEMORY_MASTER_TIMEOUT_EN aborts a wait after TIMEOUT_CYCLES
// without a response and pulses error; without it error stays 0.
module memory_burst_master
  import memory_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned LENGTH_WIDTH   = 8
) (
  input logic                   clk,
  input logic                   reset,
  memory_burst_master_if.master bus
);

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [LENGTH_WIDTH-1:0] remaining_q;
  logic [DATA_W-1:0]       rd_data_q;
  logic [DATA_W-1:0]       write_data_q;

  logic cmd_ready_q, wr_ready_q, rd_valid_q, done_q, error_q;
  logic memory_read_q, memory_write_q;

  logic load_cmd, rd_capture, wr_capture, advance, abort;
  logic last_word;
  logic tmo_expire_c;

  assign last_word = (remaining_q == '0);

`ifdef MEMORY_MASTER_TIMEOUT_EN
  logic tmo_start, tmo_active;
  assign tmo_start  = (state_q == RD_REQ)  || (state_q == WR_REQ);
  assign tmo_active = (state_q == RD_WAIT) || (state_q == WR_WAIT);

  memory_master_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .start   (tmo_start),
    .active  (tmo_active),
    .expire_c(tmo_expire_c)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_expire_c   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath enables; handshakes use the visible registered outputs.
  always_comb begin
    state_d    = state_q;
    load_cmd   = 1'b0;
    rd_capture = 1'b0;
    wr_capture = 1'b0;
    advance    = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          load_cmd = 1'b1;
          state_d  = (op_t'(bus.cmd_write) == OP_WRITE) ? WR_DATA : RD_REQ;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        // A response wins over expiry in the final count cycle.
        if (bus.sync_read_response) begin
          rd_capture = 1'b1;
          state_d    = RD_HOLD;
        end else if (tmo_expire_c) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      RD_HOLD: begin
        if (rd_valid_q && bus.rd_ready) begin
          advance = !last_word;
          state_d = last_word ? DONE : RD_REQ;
        end
      end
      WR_DATA: begin
        if (wr_ready_q && bus.wr_valid) begin
          wr_capture = 1'b1;
          state_d    = WR_REQ;
        end
      end
      WR_REQ:  state_d = WR_WAIT;
      WR_WAIT: begin
        if (bus.sync_write_response) begin
          advance = !last_word;
          state_d = last_word ? DONE : WR_DATA;
        end else if (tmo_expire_c) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered status/strobe outputs, decoded from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_ready_q    <= 1'b0;
      wr_ready_q     <= 1'b0;
      rd_valid_q     <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      memory_read_q  <= 1'b0;
      memory_write_q <= 1'b0;
    end else begin
      cmd_ready_q    <= (state_d == IDLE);
      wr_ready_q     <= (state_d == WR_DATA);
      rd_valid_q     <= (state_d == RD_HOLD);
      done_q         <= (state_d == DONE);
      error_q        <= abort;
      memory_read_q  <= (state_d == RD_REQ);
      memory_write_q <= (state_d == WR_REQ);
    end
  end

  // Address, word counter and data holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      rd_data_q    <= '0;
      write_data_q <= '0;
    end else begin
      if (load_cmd) begin
        addr_q      <= word_align(bus.cmd_address);
        remaining_q <= bus.cmd_length;
      end else if (advance) begin
        addr_q      <= addr_q + ADDR_W'(WORD_STRIDE);
        remaining_q <= remaining_q - LENGTH_WIDTH'(1);
      end
      if (rd_capture) rd_data_q    <= bus.read_sync;
      if (wr_capture) write_data_q <= bus.wr_data;
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.wr_ready     = wr_ready_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.memory_read  = memory_read_q;
  assign bus.memory_write = memory_write_q;
  assign bus.address      = addr_q;
  assign bus.write_data   = write_data_q;

endmodule

// File: tb/tb_memory_burst_master.sv
// Bench for memory_burst_master: memory responder, randomised data
// producer/consumer, and a transaction-level expectation model (expected
// memory accesses and read words per burst) checked every cycle.
module tb_memory_burst_master;

  localparam int unsigned LW  = 8;
  localparam int unsigned TMO = 16;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } acc_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  memory_burst_master_if #(.LENGTH_WIDTH(LW)) bus ();

  memory_burst_master #(
    .TIMEOUT_CYCLES(TMO),
    .LENGTH_WIDTH  (LW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  acc_t        exp_acc[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wr_src[$];
  logic [31:0] strobe_log[$];
  int          exp_done     = 0;
  int          wr_hs        = 0;
  int          rd_pct       = 100;
  int          wr_pct       = 100;
  bit          silent       = 1'b0;
  bit          rd_force_low = 1'b0;
  bit          expect_error = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Memory: samples a strobe, answers one cycle later.
  initial begin : responder
    bit          pend_rd, pend_wr;
    logic [31:0] pend_data;
    pend_rd = 0; pend_wr = 0; pend_data = '0;
    bus.sync_read_response  = 1'b0;
    bus.sync_write_response = 1'b0;
    bus.read_sync           = '0;
    forever begin
      @(posedge clk); #1;
      bus.sync_read_response  = pend_rd && !silent;
      bus.sync_write_response = pend_wr && !silent;
      bus.read_sync           = pend_data;
      pend_rd = bus.memory_read;
      pend_wr = bus.memory_write;
      if (bus.memory_read)
        pend_data = mem.exists(bus.address) ? mem[bus.address] : init_word(bus.address);
      if (bus.memory_write) mem[bus.address] = bus.write_data;
    end
  end

  // Read consumer with random backpressure.
  initial begin : rd_driver
    bus.rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.rd_ready = rd_force_low ? 1'b0 : ($urandom_range(0, 99) < rd_pct);
    end
  end

  // Write producer: offers queued words, pops after each handshake.
  initial begin : wr_driver
    bit          pv, pr;
    logic [31:0] tmp;
    pv = 0; pr = 0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    forever begin
      @(negedge clk);
      if (pv && pr && wr_src.size() != 0) begin
        tmp = wr_src.pop_front();
        wr_hs++;
      end
      if (wr_src.size() != 0 && $urandom_range(0, 99) < wr_pct) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = wr_src[0];
      end else begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = $urandom;
      end
      pv = bus.wr_valid;
      pr = bus.wr_ready;
    end
  end

  // Per-cycle compare against the transaction model.
  initial begin : monitor
    bit          prev_hold, prev_strobe, prev_done, strobe;
    logic [31:0] prev_data;
    acc_t        e;
    logic [31:0] d;
    prev_hold = 0; prev_strobe = 0; prev_done = 0; prev_data = '0;
    forever begin
      @(negedge clk); #1;
      if (!reset) begin
        prev_hold = 0; prev_strobe = 0; prev_done = 0;
        continue;
      end
      check("strobe_exclusive", 32'(bus.memory_read & bus.memory_write), 32'd0);
      check("single_phase", 32'($countones({bus.cmd_ready, bus.memory_read, bus.memory_write,
            bus.rd_valid, bus.wr_ready, bus.done}) <= 1), 32'd1);
      strobe = bus.memory_read || bus.memory_write;
      if (strobe) begin
        strobe_log.push_back(bus.address);
        if (prev_strobe) check("strobe_one_cycle", 32'd1, 32'd0);
        if (exp_acc.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = exp_acc.pop_front();
          check("strobe_op", 32'(bus.memory_write), 32'(e.wr));
          check("strobe_addr", bus.address, e.addr);
          if (e.wr) check("write_data", bus.write_data, e.data);
        end
      end
      prev_strobe = strobe;
      if (prev_hold) begin
        check("rd_valid_held", 32'(bus.rd_valid), 32'd1);
        check("rd_data_held", bus.rd_data, prev_data);
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_rd.size() == 0) begin
          check("unexpected_rd_word", 32'd1, 32'd0);
        end else begin
          d = exp_rd.pop_front();
          check("rd_data", bus.rd_data, d);
        end
      end
      prev_hold = bus.rd_valid && !bus.rd_ready;
      prev_data = bus.rd_data;
      if (bus.done) begin
        if (prev_done) check("done_one_cycle", 32'd1, 32'd0);
        if (exp_done == 0) check("unexpected_done", 32'd1, 32'd0);
        else exp_done--;
      end
      prev_done = bus.done;
      if (bus.error) check("error_expected", 32'(expect_error), 32'd1);
    end
  end

  // Queue a burst in the model, then offer the command until accepted.
  task automatic issue_cmd(input bit wr, input logic [31:0] addr, input int len,
                           input bit use_seq, input bit scramble);
    logic [31:0] a;
    acc_t        e;
    int          n;
    a = {addr[31:2], 2'b00};
    for (int i = 0; i <= len; i++) begin
      e.wr   = wr;
      e.addr = a;
      if (wr) begin
        e.data = use_seq ? 32'(i + 1) : 32'($urandom);
        ref_mem[a] = e.data;
        wr_src.push_back(e.data);
      end else begin
        e.data = ref_rd(a);
        exp_rd.push_back(e.data);
      end
      exp_acc.push_back(e);
      a = a + 32'd4;
    end
    exp_done++;
    @(negedge clk);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = wr;
    bus.cmd_address = addr;
    bus.cmd_length  = LW'(len);
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    if (scramble) begin
      bus.cmd_write   = $urandom_range(0, 1);
      bus.cmd_address = $urandom;
      bus.cmd_length  = LW'($urandom);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_done != 0 || exp_acc.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("burst_complete", 32'(exp_done), 32'd0);
    check("accesses_left", 32'(exp_acc.size()), 32'd0);
    check("reads_left", 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"},    32'(bus.cmd_ready), 32'd0);
    check({tag, "_wr_ready"},     32'(bus.wr_ready), 32'd0);
    check({tag, "_rd_valid"},     32'(bus.rd_valid), 32'd0);
    check({tag, "_rd_data"},      bus.rd_data, 32'd0);
    check({tag, "_done"},         32'(bus.done), 32'd0);
    check({tag, "_error"},        32'(bus.error), 32'd0);
    check({tag, "_memory_read"},  32'(bus.memory_read), 32'd0);
    check({tag, "_memory_write"}, 32'(bus.memory_write), 32'd0);
    check({tag, "_address"},      bus.address, 32'd0);
    check({tag, "_write_data"},   bus.write_data, 32'd0);
  endtask

  task automatic flush_model();
    exp_acc.delete();
    exp_rd.delete();
    wr_src.delete();
    exp_done = 0;
  endtask

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    logic [31:0] addr;
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_address = '0;
    bus.cmd_length  = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Single read with exact latency.
    mem[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10] = 32'hDEAD_BEEF;
    rd_pct = 100;
    issue_cmd(1'b0, 32'h13, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("single_memory_read", 32'(bus.memory_read), 32'd1);
    check("single_address", bus.address, 32'h10);
    @(negedge clk);
    check("single_rd_valid_early", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    check("single_rd_valid", 32'(bus.rd_valid), 32'd1);
    check("single_rd_data", bus.rd_data, 32'hDEAD_BEEF);
    wait_done(50);
    check("single_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);

    // Write burst 1..4 at 0x100 and read back.
    wr_hs = 0; wr_pct = 100;
    issue_cmd(1'b1, 32'h100, 3, 1'b1, 1'b0);
    wait_done(100);
    check("wr_handshakes", 32'(wr_hs), 32'd4);
    check("mem_0x100", mem.exists(32'h100) ? mem[32'h100] : 32'hX, 32'd1);
    check("mem_0x10C", mem.exists(32'h10C) ? mem[32'h10C] : 32'hX, 32'd4);
    issue_cmd(1'b0, 32'h100, 3, 1'b0, 1'b1);
    wait_done(100);

    // Backpressure: rd_ready held low for 5 cycles.
    rd_force_low = 1'b1;
    strobe_log.delete();
    issue_cmd(1'b0, 32'h200, 1, 1'b0, 1'b0);
    n = 0;
    while (!bus.rd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_rd_valid", 32'(bus.rd_valid), 32'd1);
      check("bp_rd_data", bus.rd_data, init_word(32'h200));
      check("bp_no_read", 32'(bus.memory_read), 32'd0);
      @(negedge clk);
    end
    check("bp_one_strobe", 32'(strobe_log.size()), 32'd1);
    rd_force_low = 1'b0;
    wait_done(100);

    // Address wrap.
    strobe_log.delete();
    issue_cmd(1'b0, 32'hFFFF_FFFC, 1, 1'b0, 1'b0);
    wait_done(100);
    check("wrap_count", 32'(strobe_log.size()), 32'd2);
    if (strobe_log.size() >= 2) begin
      check("wrap_addr0", strobe_log[0], 32'hFFFF_FFFC);
      check("wrap_addr1", strobe_log[1], 32'h0000_0000);
    end

    // Reset during the wait of word 2 of 4.
    strobe_log.delete();
    issue_cmd(1'b0, 32'h300, 3, 1'b0, 1'b0);
    n = 0;
    while (strobe_log.size() < 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_word2", 32'(strobe_log.size()), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    flush_model();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(bus.done), 32'd0);
    end
    check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Silent memory.
    silent = 1'b1;
    strobe_log.delete();
    issue_cmd(1'b0, 32'h400, 0, 1'b0, 1'b0);
    exp_done--;
    exp_rd.delete();
    n = 0;
    while (strobe_log.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_strobe_seen", 32'(strobe_log.size()), 32'd1);
`ifdef MEMORY_MASTER_TIMEOUT_EN
    expect_error = 1'b1;
    for (int i = 2; i <= 16; i++) begin
      @(negedge clk);
      check("tmo_no_error_yet", 32'(bus.error), 32'd0);
    end
    @(negedge clk);
    check("tmo_error", 32'(bus.error), 32'd1);
    check("tmo_idle", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    check("tmo_error_pulse", 32'(bus.error), 32'd0);
    check("tmo_no_done", 32'(bus.done), 32'd0);
    expect_error = 1'b0;
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("wait_no_error", 32'(bus.error), 32'd0);
      check("wait_no_rd_valid", 32'(bus.rd_valid), 32'd0);
    end
    check("wait_still_busy", 32'(bus.cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
`endif
    silent = 1'b0;
    flush_model();
    @(negedge clk);

    // Randomised bursts.
    for (int k = 0; k < 24; k++) begin
      rd_pct = $urandom_range(30, 100);
      wr_pct = $urandom_range(30, 100);
      if ($urandom_range(0, 4) == 0) addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else addr = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      issue_cmd(1'($urandom_range(0, 1)), addr, $urandom_range(0, 7), 1'b0, 1'b1);
      wait_done(400);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
